// File: rtl/mmio_pkg.sv
`default_nettype none
// ============================================================================
// Package : mmio_pkg
// Brief   : Shared constants for the MMIO bridge: base address, register
//           offsets and TX_STATUS bit layout.
// Rev     : 1.0
// ============================================================================
package mmio_pkg;

    localparam logic [15:0] MMIO_BASE_DEFAULT = 16'hFF00;

    localparam logic [15:0] OFF_LEDS          = 16'd0;
    localparam logic [15:0] OFF_SWITCHES      = 16'd1;
    localparam logic [15:0] OFF_TX_DATA       = 16'd2;
    localparam logic [15:0] OFF_TX_STATUS     = 16'd3;
    localparam logic [15:0] OFF_TIMER_COUNT   = 16'd4;
    localparam logic [15:0] OFF_TIMER_COMPARE = 16'd5;
    localparam logic [15:0] OFF_TIMER_FLAG    = 16'd6;

    localparam int STAT_EMPTY_BIT = 0;
    localparam int STAT_FULL_BIT  = 1;
    localparam int STAT_OVF_BIT   = 2;
    localparam int STAT_COUNT_LSB = 4;
    localparam int STAT_COUNT_W   = 5;

    function automatic logic [15:0] tx_status(
        input logic       empty,
        input logic       full,
        input logic       overflow,
        input logic [4:0] count
    );
        logic [15:0] v;
        v = '0;
        v[STAT_EMPTY_BIT] = empty;
        v[STAT_FULL_BIT]  = full;
        v[STAT_OVF_BIT]   = overflow;
        v[STAT_COUNT_LSB +: STAT_COUNT_W] = count;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tx_fifo.sv
`default_nettype none
// ============================================================================
// Module : tx_fifo
// Brief  : Power-of-two byte FIFO with empty/full/count and an overflow pulse
//          for a push that is dropped because the FIFO is full.
// Rev    : 1.0
// ============================================================================
module tx_fifo #(
    parameter  int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [7:0]       i_push_data,
    input  logic             i_pop,
    output logic [7:0]       o_head,
    output logic             o_empty,
    output logic             o_full,
    output logic [PTR_W:0]   o_count,
    output logic             o_overflow
);

    localparam logic [PTR_W:0] C_DEPTH = (PTR_W + 1)'(DEPTH);

    logic [7:0]       r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_do_pop;
    logic             w_do_push;

    assign o_empty    = (r_count == '0);
    assign o_full     = (r_count == C_DEPTH);
    assign o_count    = r_count;
    assign w_do_pop   = i_pop & ~o_empty;
    // A pop in the same cycle frees the slot the push needs.
    assign w_do_push  = i_push & (~o_full | w_do_pop);
    assign o_overflow = i_push & o_full & ~w_do_pop;
    assign o_head     = o_empty ? 8'h00 : r_mem[r_rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mmio_bridge.sv
`default_nettype none
// ============================================================================
// Module : mmio_bridge
// Brief  : Splits CPU data accesses between block RAM and an MMIO page (LEDs,
//          switches, TX FIFO); timer registers built when MMIO_TIMER_EN is set.
// Rev    : 1.0
// ============================================================================
module mmio_bridge
    import mmio_pkg::*;
#(
    parameter logic [15:0] MMIO_BASE  = MMIO_BASE_DEFAULT,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cpu_write_enable,
    input  logic [15:0] cpu_address,
    input  logic [15:0] cpu_write_data,
    output logic [15:0] cpu_read_data,
    output logic        ram_write_enable,
    output logic [15:0] ram_address,
    output logic [15:0] ram_write_data,
    input  logic [15:0] ram_read_data,
    input  logic [9:0]  switches,
    output logic [9:0]  leds,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam int FIFO_PTR_W = $clog2(FIFO_DEPTH);

    logic                w_hit;
    logic [15:0]         w_offset;
    logic                w_mmio_we;
    logic                w_push;
    logic                w_ovf_clr;
    logic                w_empty;
    logic                w_full;
    logic                w_ovf_pulse;
    logic [FIFO_PTR_W:0] w_fifo_count;
    logic [15:0]         w_tx_status;
    logic [15:0]         w_mmio_rdata;

    logic [9:0]          r_leds;
    logic [9:0]          r_sw_meta;
    logic [9:0]          r_sw_sync;
    logic                r_overflow;
    logic                r_hit;
    logic [15:0]         r_mmio_rdata;

    assign w_hit            = (cpu_address >= MMIO_BASE);
    assign w_offset         = cpu_address - MMIO_BASE;
    assign w_mmio_we        = cpu_write_enable & w_hit;
    assign w_push           = w_mmio_we & (w_offset == OFF_TX_DATA);
    assign w_ovf_clr        = w_mmio_we & (w_offset == OFF_TX_STATUS);

    assign ram_write_enable = cpu_write_enable & ~w_hit;
    assign ram_address      = cpu_address;
    assign ram_write_data   = cpu_write_data;

    assign cpu_read_data    = r_hit ? r_mmio_rdata : ram_read_data;
    assign leds             = r_leds;
    assign tx_valid         = ~w_empty;
    assign w_tx_status      = tx_status(w_empty, w_full, r_overflow,
                                        STAT_COUNT_W'(w_fifo_count));

    tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk         (clock),
        .rst         (reset),
        .i_push      (w_push),
        .i_push_data (cpu_write_data[7:0]),
        .i_pop       (tx_ready),
        .o_head      (tx_data),
        .o_empty     (w_empty),
        .o_full      (w_full),
        .o_count     (w_fifo_count),
        .o_overflow  (w_ovf_pulse)
    );

`ifdef MMIO_TIMER_EN
    logic [15:0] r_timer_count;
    logic [15:0] r_timer_cmp;
    logic        r_timer_flag;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_timer_count <= '0;
            r_timer_cmp   <= 16'hFFFF;
            r_timer_flag  <= 1'b0;
        end else begin
            if (w_mmio_we && (w_offset == OFF_TIMER_COUNT)) begin
                r_timer_count <= cpu_write_data;
            end else begin
                r_timer_count <= r_timer_count + 1'b1;
            end
            if (w_mmio_we && (w_offset == OFF_TIMER_COMPARE)) begin
                r_timer_cmp <= cpu_write_data;
            end
            // A match in the same cycle as a clear keeps the flag set.
            if (r_timer_count == r_timer_cmp) begin
                r_timer_flag <= 1'b1;
            end else if (w_mmio_we && (w_offset == OFF_TIMER_FLAG) && cpu_write_data[0]) begin
                r_timer_flag <= 1'b0;
            end
        end
    end
`endif

    always_comb begin
        w_mmio_rdata = '0;
        if (w_hit) begin
            case (w_offset)
                OFF_LEDS:          w_mmio_rdata = {6'd0, r_leds};
                OFF_SWITCHES:      w_mmio_rdata = {6'd0, r_sw_sync};
                OFF_TX_STATUS:     w_mmio_rdata = w_tx_status;
`ifdef MMIO_TIMER_EN
                OFF_TIMER_COUNT:   w_mmio_rdata = r_timer_count;
                OFF_TIMER_COMPARE: w_mmio_rdata = r_timer_cmp;
                OFF_TIMER_FLAG:    w_mmio_rdata = {15'd0, r_timer_flag};
`endif
                default:           w_mmio_rdata = '0;
            endcase
        end
    end

    // Reset leaves the read path selecting the zeroed MMIO register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_leds       <= '0;
            r_sw_meta    <= '0;
            r_sw_sync    <= '0;
            r_overflow   <= 1'b0;
            r_hit        <= 1'b1;
            r_mmio_rdata <= '0;
        end else begin
            r_sw_meta    <= switches;
            r_sw_sync    <= r_sw_meta;
            r_hit        <= w_hit;
            r_mmio_rdata <= w_mmio_rdata;
            if (w_mmio_we && (w_offset == OFF_LEDS)) begin
                r_leds <= cpu_write_data[9:0];
            end
            if (w_ovf_clr) begin
                r_overflow <= 1'b0;
            end else if (w_ovf_pulse) begin
                r_overflow <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mmio_bridge.sv
`default_nettype none
// ============================================================================
// Module : tb_mmio_bridge
// Brief  : Self-checking bench for mmio_bridge (vector table, directed FIFO,
//          switch, timer and reset sequences, randomized model comparison).
// Rev    : 1.0
// ============================================================================
module tb_mmio_bridge;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_write_enable = 1'b0;
    logic [15:0] cpu_address = 16'h0020;
    logic [15:0] cpu_write_data = 16'h0000;
    logic [15:0] cpu_read_data;
    logic        ram_write_enable;
    logic [15:0] ram_address;
    logic [15:0] ram_write_data;
    logic [15:0] ram_read_data = 16'h0000;
    logic [9:0]  switches = 10'h000;
    logic [9:0]  leds;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    logic ram_we_seen;
    logic txv_seen;

    logic [15:0] ram_mem [256] = '{default: 16'h0000};

    // Reference model state
    logic [15:0] ref_ram [256] = '{default: 16'h0000};
    logic [7:0]  q [$];
    logic        ovf_m  = 1'b0;
    logic [9:0]  leds_m = 10'h000;
    logic [9:0]  sw_m   = 10'h000;

    mmio_bridge #(
        .MMIO_BASE  (16'hFF00),
        .FIFO_DEPTH (8)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .cpu_write_enable (cpu_write_enable),
        .cpu_address      (cpu_address),
        .cpu_write_data   (cpu_write_data),
        .cpu_read_data    (cpu_read_data),
        .ram_write_enable (ram_write_enable),
        .ram_address      (ram_address),
        .ram_write_data   (ram_write_data),
        .ram_read_data    (ram_read_data),
        .switches         (switches),
        .leds             (leds),
        .tx_data          (tx_data),
        .tx_valid         (tx_valid),
        .tx_ready         (tx_ready)
    );

    always #5 clock = ~clock;

    // Synchronous block RAM, read-before-write
    always @(posedge clock) begin
        if (ram_write_enable) ram_mem[ram_address[7:0]] <= ram_write_data;
        ram_read_data <= ram_mem[ram_address[7:0]];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic cycle(input logic we, input logic [15:0] a, input logic [15:0] d);
        cpu_write_enable = we;
        cpu_address      = a;
        cpu_write_data   = d;
        #1;
        ram_we_seen = ram_write_enable;
        txv_seen    = tx_valid;
        @(posedge clock);
        #1;
    endtask

    function automatic logic [15:0] model_read(input logic [15:0] a);
        logic [15:0] off;
        int cnt;
        if (a < 16'hFF00) return ref_ram[a[7:0]];
        off = a - 16'hFF00;
        cnt = q.size();
        case (off)
            16'd0:   return {6'd0, leds_m};
            16'd1:   return {6'd0, sw_m};
            16'd3:   return 16'((cnt * 16) + (ovf_m ? 4 : 0) + (cnt == 8 ? 2 : 0) + (cnt == 0 ? 1 : 0));
            default: return 16'h0000;
        endcase
    endfunction

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        exp_ram_we;
        logic [15:0] exp_rd;
        logic [9:0]  exp_leds;
    } vec_t;

    vec_t vecs [14];

    initial begin
        #500000;
        $display("FAIL timeout: actual running required finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic        found;
        logic [15:0] offs [$];
        logic [7:0]  exp_b [$];

        vecs[0]  = '{1'b1, 16'h0010, 16'h1234, 1'b1, 16'h0000, 10'h000};
        vecs[1]  = '{1'b0, 16'h0010, 16'h0000, 1'b0, 16'h1234, 10'h000};
        vecs[2]  = '{1'b1, 16'hFF00, 16'h03FF, 1'b0, 16'h0000, 10'h3FF};
        vecs[3]  = '{1'b0, 16'hFF00, 16'h0000, 1'b0, 16'h03FF, 10'h3FF};
        vecs[4]  = '{1'b1, 16'hFF00, 16'hFC00, 1'b0, 16'h03FF, 10'h000};
        vecs[5]  = '{1'b1, 16'hFF00, 16'hFFFF, 1'b0, 16'h0000, 10'h3FF};
        vecs[6]  = '{1'b0, 16'hFF00, 16'h0000, 1'b0, 16'h03FF, 10'h3FF};
        vecs[7]  = '{1'b1, 16'hFEFF, 16'h5555, 1'b1, 16'h0000, 10'h3FF};
        vecs[8]  = '{1'b0, 16'hFEFF, 16'h0000, 1'b0, 16'h5555, 10'h3FF};
        vecs[9]  = '{1'b1, 16'hFF01, 16'hAAAA, 1'b0, 16'h0000, 10'h3FF};
        vecs[10] = '{1'b0, 16'hFF03, 16'h0000, 1'b0, 16'h0001, 10'h3FF};
        vecs[11] = '{1'b0, 16'hFF02, 16'h0000, 1'b0, 16'h0000, 10'h3FF};
        vecs[12] = '{1'b0, 16'hFF07, 16'h0000, 1'b0, 16'h0000, 10'h3FF};
        vecs[13] = '{1'b0, 16'hFFFF, 16'h0000, 1'b0, 16'h0000, 10'h3FF};

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        chk("reset_rd", cpu_read_data, 16'h0000);
        chk("reset_tx_valid", tx_valid, 1'b0);
        chk("reset_tx_data", tx_data, 8'h00);
        chk("reset_leds", leds, 10'h000);
        reset = 1'b0;

        for (int i = 0; i < 14; i++) begin
            cycle(vecs[i].we, vecs[i].addr, vecs[i].wdata);
            chk($sformatf("vec%0d_ram_we", i), ram_we_seen, vecs[i].exp_ram_we);
            chk($sformatf("vec%0d_rd", i), cpu_read_data, vecs[i].exp_rd);
            chk($sformatf("vec%0d_leds", i), leds, vecs[i].exp_leds);
        end

        // Switch synchroniser: two flops before the value is readable
        switches = 10'h2A5;
        cycle(1'b0, 16'hFF01, 16'h0);
        chk("sw_lat1", cpu_read_data, 16'h0000);
        cycle(1'b0, 16'hFF01, 16'h0);
        chk("sw_lat2", cpu_read_data, 16'h0000);
        cycle(1'b0, 16'hFF01, 16'h0);
        chk("sw_val", cpu_read_data, 16'h02A5);

        // Overflow: 9 pushes into 8 entries
        tx_ready = 1'b0;
        for (int i = 0; i < 9; i++) cycle(1'b1, 16'hFF02, 16'(8'h41 + i));
        cycle(1'b0, 16'hFF03, 16'h0);
        chk("ovf_status", cpu_read_data, 16'h0086);
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("drain%0d_valid", i), tx_valid, 1'b1);
            chk($sformatf("drain%0d_data", i), tx_data, 8'(8'h41 + i));
            cycle(1'b0, 16'h0020, 16'h0);
        end
        chk("drained_valid", tx_valid, 1'b0);
        cycle(1'b0, 16'hFF03, 16'h0);
        chk("drained_status", cpu_read_data, 16'h0005);
        tx_ready = 1'b0;
        cycle(1'b1, 16'hFF03, 16'h0);
        cycle(1'b0, 16'hFF03, 16'h0);
        chk("ovf_cleared", cpu_read_data, 16'h0001);

        // Full FIFO: push with simultaneous pop is accepted
        cycle(1'b1, 16'hFF02, 16'h0060);
        chk("no_fallthrough", txv_seen, 1'b0);
        chk("push_valid_next", tx_valid, 1'b1);
        for (int i = 1; i < 8; i++) cycle(1'b1, 16'hFF02, 16'(8'h60 + i));
        cycle(1'b0, 16'hFF03, 16'h0);
        chk("full_status", cpu_read_data, 16'h0082);
        tx_ready = 1'b1;
        cycle(1'b1, 16'hFF02, 16'h0050);
        tx_ready = 1'b0;
        chk("pushpop_head", tx_data, 8'h61);
        cycle(1'b0, 16'hFF03, 16'h0);
        chk("pushpop_status", cpu_read_data, 16'h0082);
        exp_b = {8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h50};
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("pp_drain%0d", i), {tx_valid, tx_data}, {1'b1, exp_b[i]});
            cycle(1'b0, 16'h0020, 16'h0);
        end
        tx_ready = 1'b0;
        chk("pp_empty", tx_valid, 1'b0);
        cycle(1'b0, 16'hFF03, 16'h0);
        chk("pp_status", cpu_read_data, 16'h0001);

`ifdef MMIO_TIMER_EN
        cycle(1'b1, 16'hFF06, 16'h0001);
        cycle(1'b1, 16'hFF05, 16'h0005);
        cycle(1'b1, 16'hFF04, 16'h0000);
        found = 1'b0;
        for (int k = 0; k < 7; k++) begin
            cycle(1'b0, 16'hFF06, 16'h0);
            if (cpu_read_data == 16'h0001) found = 1'b1;
        end
        chk("timer_flag_set", found, 1'b1);
        cycle(1'b1, 16'hFF06, 16'h0001);
        cycle(1'b0, 16'hFF06, 16'h0);
        chk("timer_flag_clr", cpu_read_data, 16'h0000);
        cycle(1'b0, 16'hFF05, 16'h0);
        chk("timer_cmp", cpu_read_data, 16'h0005);
        cycle(1'b1, 16'hFF04, 16'hFFFE);
        cycle(1'b0, 16'hFF04, 16'h0);
        chk("timer_fffe", cpu_read_data, 16'hFFFE);
        cycle(1'b0, 16'hFF04, 16'h0);
        chk("timer_ffff", cpu_read_data, 16'hFFFF);
        cycle(1'b0, 16'hFF04, 16'h0);
        chk("timer_wrap", cpu_read_data, 16'h0000);
        offs = {16'd1, 16'd7, 16'd8, 16'hFF};
`else
        found = 1'b0;
        cycle(1'b1, 16'hFF04, 16'h1234);
        chk("notimer_ram_we", ram_we_seen, 1'b0);
        cycle(1'b1, 16'hFF05, 16'h0005);
        cycle(1'b1, 16'hFF06, 16'h0001);
        for (int k = 4; k < 7; k++) begin
            cycle(1'b0, 16'(16'hFF00 + k), 16'h0);
            chk($sformatf("notimer_rd%0d", k), cpu_read_data, 16'h0000);
        end
        offs = {16'd1, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'hFF};
`endif

        // Reset in the middle of operation
        for (int i = 0; i < 3; i++) cycle(1'b1, 16'hFF02, 16'(8'h70 + i));
        cycle(1'b1, 16'hFF00, 16'h0155);
        chk("pre_rst_valid", tx_valid, 1'b1);
        chk("pre_rst_leds", leds, 10'h155);
        reset = 1'b1;
        #1;
        chk("rst_async_valid", tx_valid, 1'b0);
        chk("rst_async_data", tx_data, 8'h00);
        chk("rst_async_leds", leds, 10'h000);
        chk("rst_async_rd", cpu_read_data, 16'h0000);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        chk("post_rst_rd", cpu_read_data, 16'h0000);
        cycle(1'b0, 16'hFF03, 16'h0);
        chk("post_rst_status", cpu_read_data, 16'h0001);
        repeat (3) cycle(1'b0, 16'h0020, 16'h0);

        // Randomized traffic against the reference model
        sw_m = 10'h2A5;
        for (int n = 0; n < 400; n++) begin
            int          op;
            logic        we;
            logic [15:0] a;
            logic [15:0] d;
            logic [15:0] exp_rd;
            logic        exp_rwe;
            op = $urandom_range(0, 10);
            d  = 16'($urandom);
            we = 1'b0;
            a  = 16'(16'h0020 + $urandom_range(0, 95));
            case (op)
                0:       begin we = 1'b1; a = 16'hFF00; end
                1:       begin we = 1'b0; a = 16'hFF00; end
                2, 3, 4: begin we = 1'b1; a = 16'hFF02; end
                5:       begin we = 1'b0; a = 16'hFF03; end
                6:       begin we = 1'b1; a = 16'hFF03; end
                7:       begin
                    we = 1'($urandom);
                    a  = 16'(16'hFF00 + offs[$urandom_range(0, offs.size() - 1)]);
                end
                8:       we = 1'b1;
                default: we = 1'b0;
            endcase
            tx_ready = ($urandom_range(0, 3) == 0);

            exp_rd  = model_read(a);
            exp_rwe = we && (a < 16'hFF00);
            if (tx_ready && q.size() > 0) void'(q.pop_front());
            if (we && a == 16'hFF02) begin
                if (q.size() < 8) q.push_back(d[7:0]);
                else ovf_m = 1'b1;
            end
            if (we && a == 16'hFF03) ovf_m = 1'b0;
            if (we && a == 16'hFF00) leds_m = d[9:0];
            if (exp_rwe) ref_ram[a[7:0]] = d;

            cycle(we, a, d);
            chk("rnd_ram_we", ram_we_seen, exp_rwe);
            chk("rnd_rd", cpu_read_data, exp_rd);
            chk("rnd_tx_valid", tx_valid, (q.size() > 0));
            if (q.size() > 0) chk("rnd_tx_data", tx_data, q[0]);
            chk("rnd_leds", leds, leds_m);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mmio_bridge.md
Name: mmio_bridge

Overview:
- Sits directly downstream of the CPU's data-memory port.
- Decodes each CPU data access to either block RAM (pass-through) or a small memory-mapped peripheral page: LEDs, switches, a TX byte FIFO, and an optional timer.
- Returns read data with the same one-cycle latency as synchronous block RAM, so the CPU controller sees a uniform data port.

Parameters:
- MMIO_BASE, 16'hFF00: addresses >= MMIO_BASE hit the peripheral page; all lower addresses go to RAM.
- FIFO_DEPTH, 8: TX FIFO entries. Must be a power of two, 2..16.

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high
- cpu_write_enable  input  1  data write strobe from CPU
- cpu_address  input  16  data address from CPU
- cpu_write_data  input  16  data write value from CPU
- cpu_read_data  output  16  read data to CPU, valid one cycle after address
- ram_write_enable  output  1  RAM write strobe
- ram_address  output  16  RAM address (= cpu_address)
- ram_write_data  output  16  RAM write data (= cpu_write_data)
- ram_read_data  input  16  synchronous RAM read data, one-cycle latency
- switches  input  10  asynchronous board switches
- leds  output  10  LED register
- tx_data  output  8  FIFO head byte
- tx_valid  output  1  FIFO non-empty
- tx_ready  input  1  consumer accepts head this cycle

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high (ports clock, reset).
- Decode:
  - hit = (cpu_address >= MMIO_BASE).
  - ram_write_enable = cpu_write_enable & ~hit. Address and data pass through combinationally.
- Read path, latency 1:
  - Registered hit_q and mmio_rdata_q.
  - cpu_read_data = hit_q ? mmio_rdata_q : ram_read_data.
  - Back-to-back accesses are allowed every cycle.
- Register map (offset from MMIO_BASE):
  - 0 LEDS, RW, bits[9:0]. Upper read bits are 0.
  - 1 SWITCHES, RO. 2-flop synchronised. Writes are ignored.
  - 2 TX_DATA, WO. A write pushes cpu_write_data[7:0]. Reads return 0.
  - 3 TX_STATUS, RO:
    - bit0 empty, bit1 full, bit2 overflow (sticky), bits[8:4] count.
    - Any write clears overflow.
  - 4 TIMER_COUNT, 5 TIMER_COMPARE, 6 TIMER_FLAG: only when the optional feature is built in.
  - Every other offset reads 0; writes to it are ignored.
- FIFO:
  - tx_valid = ~empty; tx_data = head entry.
  - Pop when tx_valid & tx_ready.
  - Push while full with no pop: byte dropped, overflow set.
  - Push while full with a simultaneous pop: push accepted, count unchanged.
  - Push while empty: tx_valid rises the next cycle. There is no fall-through.
  - Read/write pointers wrap modulo FIFO_DEPTH.
  - Count ranges 0..FIFO_DEPTH.
- Reset values:
  - leds = 0, FIFO empty, tx_valid = 0, tx_data = 0.
  - overflow = 0, switch sync flops = 0.
  - hit_q = 1 and mmio_rdata_q = 0, so cpu_read_data = 0.
  - Timer count = 0, compare = 16'hFFFF, flag = 0.
- Reset mid-operation: FIFO contents are discarded immediately and tx_valid drops asynchronously.

Optional Feature:
- Macro: MMIO_TIMER_EN.
- Defined:
  - TIMER_COUNT increments every cycle and wraps FFFF->0000. A CPU write loads the written value, and the load wins over the increment.
  - TIMER_COMPARE is RW.
  - TIMER_FLAG bit0 sets when count == compare (registered count value). Writing 1 to bit0 clears it; a set in the same cycle wins over the clear.
- Undefined: offsets 4-6 read 0, writes are ignored, and no timer flops are synthesised.

Decomposition:
- Shared package mmio_pkg:
  - MMIO_BASE default and register offset constants (OFF_LEDS..OFF_TIMER_FLAG).
  - TX_STATUS bit positions.
- One sub-module: tx_fifo.
  - Parameterised depth, synchronous push/pop.
  - Provides empty, full and count outputs, and an overflow pulse.

Test Plan:
- Write 16'h1234 to 16'h0010, then read 16'h0010 -> ram_write_enable pulses once; cpu_read_data = RAM model value 16'h1234 one cycle after address.
- Write 16'h03FF to FF00, read FF00 -> leds = 10'h3FF; read returns 16'h03FF. Write to FF00 never asserts ram_write_enable.
- Hold tx_ready = 0 and push 9 bytes 0x41..0x49 (FIFO_DEPTH = 8) -> TX_STATUS reads 16'h0086 (count 8, full, overflow). Release tx_ready -> bytes 0x41..0x48 leave in order, then tx_valid = 0 and status = 16'h0005.
- With FIFO full and tx_ready = 1, push 0x50 in the same cycle as a pop -> push accepted, count stays 8, no overflow; 0x50 emerges last.
- MMIO_TIMER_EN: write compare = 5, count = 0 -> flag reads 1 within 7 cycles. Write 1 to FF06 -> flag reads 0. Count wraps from FFFF to 0000.
- Assert reset while the FIFO holds 3 bytes -> tx_valid = 0 immediately; leds = 0; cpu_read_data = 0 until the first post-reset access.
